// File: rtl/limn2600_bus_arbiter_if.sv
// Limn2600 memory-bus bundle: two requesting masters (m0 = fetch, m1 = load/store)
// and the shared bank strobe/return bus.
//   slave  : arbiter view (accepts master requests, drives bank strobes)
//   master : environment view (masters issue requests, banks return rdy/rdata)
interface limn2600_bus_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned N_BANK = 3;

    // master 0 (instruction fetch)
    logic                          m0_req;
    logic                          m0_we;
    logic [ADDR_W-1:0]             m0_addr;
    logic [DATA_WIDTH-1:0]         m0_wdata;
    logic                          m0_ack;
    logic [DATA_WIDTH-1:0]         m0_rdata;
    logic                          m0_err;

    // master 1 (load/store)
    logic                          m1_req;
    logic                          m1_we;
    logic [ADDR_W-1:0]             m1_addr;
    logic [DATA_WIDTH-1:0]         m1_wdata;
    logic                          m1_ack;
    logic [DATA_WIDTH-1:0]         m1_rdata;
    logic                          m1_err;

    // bank side: one-hot ce, [0]=ROM [1]=RAM [2]=NVRAM
    logic [N_BANK-1:0]             s_ce;
    logic                          s_we;
    logic                          s_oe;
    logic [ADDR_W-1:0]             s_addr;
    logic [DATA_WIDTH-1:0]         s_wdata;
    logic [N_BANK-1:0]             s_rdy;
    logic [N_BANK*DATA_WIDTH-1:0]  s_rdata;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_ack, m0_rdata, m0_err,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_ack, m1_rdata, m1_err,
        output s_ce, s_we, s_oe, s_addr, s_wdata,
        input  s_rdy, s_rdata
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_ack, m0_rdata, m0_err,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_ack, m1_rdata, m1_err,
        input  s_ce, s_we, s_oe, s_addr, s_wdata,
        output s_rdy, s_rdata
    );
endinterface

// File: rtl/limn2600_bus_arbiter.sv
// Two-master round-robin arbiter and address decoder for the Limn2600 ROM/RAM/NVRAM banks.
// One transaction in flight: IDLE (arbitrate/decode) -> ISSUE (strobe) -> WAIT (rdy or
// timeout) -> RESP (one-cycle ack). Unmapped addresses and ROM writes skip straight to RESP.
// Ports:
//   clk  : clock, posedge
//   rst  : synchronous reset, active-low
//   bus  : limn2600_bus_arbiter_if.slave (master request/response + bank strobe/return)
module limn2600_bus_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    limn2600_bus_arbiter_if.slave bus
);
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                 state;
    logic                   gnt;        // owner of the current transaction: 0=m0, 1=m1
    logic                   rr_last;    // last contention winner: 0=m0, 1=m1
    logic                   lat_we;
    logic [2:0]             lat_bank;
    logic [CNT_W-1:0]       cnt;

    // arbitration and request mux
    logic                   both_req_c;
    logic                   any_req_c;
    logic                   gnt_c;
    logic                   req_we_c;
    logic [ADDR_W-1:0]      req_addr_c;
    logic [DATA_WIDTH-1:0]  req_wdata_c;
    logic [2:0]             dec_bank_c;
    logic                   req_bad_c;

    assign both_req_c  = bus.m0_req & bus.m1_req;
    assign any_req_c   = bus.m0_req | bus.m1_req;
    // under contention the master that did not win last time gets the bus
    assign gnt_c       = bus.m1_req & (~bus.m0_req | ~rr_last);
    assign req_we_c    = gnt_c ? bus.m1_we    : bus.m0_we;
    assign req_addr_c  = gnt_c ? bus.m1_addr  : bus.m0_addr;
    assign req_wdata_c = gnt_c ? bus.m1_wdata : bus.m0_wdata;

    // address decode on the upper half-word
    always_comb begin
        dec_bank_c = 3'b000;
        case (req_addr_c[31:16])
            16'hFFFE: dec_bank_c = 3'b001;
            16'h0000: dec_bank_c = 3'b010;
            16'hF800: dec_bank_c = 3'b100;
            default:  dec_bank_c = 3'b000;
        endcase
    end

    assign req_bad_c = (dec_bank_c == 3'b000) | (dec_bank_c[0] & req_we_c);

    // ready/data of the selected bank only; other banks' rdy is ignored
    logic                   sel_rdy_c;
    logic [DATA_WIDTH-1:0]  sel_rdata_c;

    assign sel_rdy_c = |(bus.s_rdy & lat_bank);

    always_comb begin
        sel_rdata_c = bus.s_rdata[0 +: DATA_WIDTH];
        if (lat_bank[1]) begin
            sel_rdata_c = bus.s_rdata[DATA_WIDTH +: DATA_WIDTH];
        end else if (lat_bank[2]) begin
            sel_rdata_c = bus.s_rdata[2*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // response decision for the transition into RESP
    logic                   resp_c;
    logic                   resp_err_c;
    logic                   resp_gnt_c;
    logic [DATA_WIDTH-1:0]  resp_data_c;

    always_comb begin
        resp_c      = 1'b0;
        resp_err_c  = 1'b0;
        resp_gnt_c  = gnt;
        resp_data_c = '0;
        case (state)
            IDLE: begin
                if (any_req_c && req_bad_c) begin
                    resp_c     = 1'b1;
                    resp_err_c = 1'b1;
                    resp_gnt_c = gnt_c;
                end
            end
            WAIT: begin
                if (sel_rdy_c) begin
                    resp_c      = 1'b1;
                    resp_data_c = lat_we ? '0 : sel_rdata_c;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    resp_c     = 1'b1;
                    resp_err_c = 1'b1;
                end
            end
            default: begin
                resp_c = 1'b0;
            end
        endcase
    end

    // state register with registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            gnt          <= 1'b0;
            rr_last      <= 1'b1;
            lat_we       <= 1'b0;
            lat_bank     <= 3'b000;
            cnt          <= '0;
            bus.m0_ack   <= 1'b0;
            bus.m0_err   <= 1'b0;
            bus.m0_rdata <= '0;
            bus.m1_ack   <= 1'b0;
            bus.m1_err   <= 1'b0;
            bus.m1_rdata <= '0;
            bus.s_ce     <= 3'b000;
            bus.s_we     <= 1'b0;
            bus.s_oe     <= 1'b0;
            bus.s_addr   <= '0;
            bus.s_wdata  <= '0;
        end else begin
            bus.m0_ack   <= resp_c & ~resp_gnt_c;
            bus.m0_err   <= resp_c & ~resp_gnt_c & resp_err_c;
            bus.m0_rdata <= (resp_c & ~resp_gnt_c) ? resp_data_c : '0;
            bus.m1_ack   <= resp_c & resp_gnt_c;
            bus.m1_err   <= resp_c & resp_gnt_c & resp_err_c;
            bus.m1_rdata <= (resp_c & resp_gnt_c) ? resp_data_c : '0;
            bus.s_ce     <= 3'b000;
            bus.s_we     <= 1'b0;
            bus.s_oe     <= 1'b0;

            case (state)
                IDLE: begin
                    if (any_req_c) begin
                        gnt      <= gnt_c;
                        lat_we   <= req_we_c;
                        lat_bank <= dec_bank_c;
                        if (both_req_c) begin
                            rr_last <= gnt_c;
                        end
                        if (req_bad_c) begin
                            state <= RESP;
                        end else begin
                            state       <= ISSUE;
                            bus.s_ce    <= dec_bank_c;
                            bus.s_we    <= req_we_c;
                            bus.s_oe    <= ~req_we_c;
                            bus.s_addr  <= req_addr_c;
                            bus.s_wdata <= req_wdata_c;
                        end
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (resp_c) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
